// File: rtl/rom_reader_pkg.sv
// ============================================================================
// Module      : rom_reader_pkg
// Description : Shared types and constants for the rom_reader read master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rom_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int C_BUF_DEPTH = 2;

endpackage

`default_nettype wire

// File: rtl/rom_stream_fifo.sv
// ============================================================================
// Module      : rom_stream_fifo
// Description : Two-entry register FIFO holding ROM words and their last flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_stream_fifo
    import rom_reader_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_push_last,
    input  logic             i_pop,
    output logic [1:0]       o_count,
    output logic [WIDTH-1:0] o_head_data,
    output logic             o_head_last
);

    localparam logic [1:0] C_FULL = 2'(C_BUF_DEPTH);

    logic [WIDTH-1:0] r_mem  [C_BUF_DEPTH];
    logic             r_last [C_BUF_DEPTH];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && (r_count != 2'd0);
    // A push into a full buffer is only legal alongside a pop.
    assign w_do_push = i_push && ((r_count != C_FULL) || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < C_BUF_DEPTH; i++) begin
                r_mem[i]  <= '0;
                r_last[i] <= 1'b0;
            end
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr]  <= i_push_data;
                r_last[r_wptr] <= i_push_last;
                r_wptr         <= ~r_wptr;
            end
            if (w_do_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count     = r_count;
    assign o_head_data = r_mem[r_rptr];
    assign o_head_last = r_last[r_rptr] && (r_count != 2'd0);

endmodule

`default_nettype wire

// File: rtl/rom_reader.sv
// ============================================================================
// Module      : rom_reader
// Description : Sequential ROM read master presenting words as a valid/ready
//               stream with a last-word marker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_reader
    import rom_reader_pkg::*;
#(
    parameter int ROM_WIDTH     = 1,
    parameter int ROM_ADDR_BITS = 14
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ROM_ADDR_BITS-1:0] base_addr,
    input  logic [ROM_ADDR_BITS:0]   length,
    output logic                     busy,
    output logic                     done,
    output logic [ROM_ADDR_BITS-1:0] rom_address,
    output logic                     rom_enable,
    input  logic [ROM_WIDTH-1:0]     rom_data,
    output logic [ROM_WIDTH-1:0]     m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last
);

    localparam logic [ROM_ADDR_BITS:0] C_CNT_ZERO = '0;
    localparam logic [ROM_ADDR_BITS:0] C_CNT_ONE  = {{ROM_ADDR_BITS{1'b0}}, 1'b1};

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [ROM_ADDR_BITS-1:0] r_addr;
    logic [ROM_ADDR_BITS:0]   r_issue_cnt;
    logic [ROM_ADDR_BITS:0]   r_ret_cnt;
    logic                     r_pending;
    logic                     r_pending_last;
    logic [1:0]               w_count;
    logic                     w_pop;
    logic                     w_issue;
    logic                     w_start;

    rom_stream_fifo #(
        .WIDTH (ROM_WIDTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_push      (r_pending),
        .i_push_data (rom_data),
        .i_push_last (r_pending_last),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_head_data (m_data),
        .o_head_last (m_last)
    );

    assign m_valid = (w_count != 2'd0);
    assign w_pop   = m_valid && m_ready;
    assign w_start = (r_state == ST_IDLE) && start;

    // Issue only when the word it returns is guaranteed a buffer slot.
    assign w_issue = (r_state == ST_RUN) && (r_issue_cnt != C_CNT_ZERO) &&
                     (({1'b0, w_count} + {2'b00, r_pending}) < (3'd2 + {2'b00, w_pop}));

    assign rom_enable  = w_issue;
    assign rom_address = r_addr;
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (length == C_CNT_ZERO) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_issue && (r_issue_cnt == C_CNT_ONE)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_pop && (r_ret_cnt == C_CNT_ONE)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_addr         <= '0;
            r_issue_cnt    <= '0;
            r_ret_cnt      <= '0;
            r_pending      <= 1'b0;
            r_pending_last <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_pending      <= w_issue;
            r_pending_last <= w_issue && (r_issue_cnt == C_CNT_ONE);
            if (w_start) begin
                r_addr      <= base_addr;
                r_issue_cnt <= length;
                r_ret_cnt   <= length;
            end else begin
                // The address stops advancing after the final issue so it holds.
                if (w_issue) begin
                    r_issue_cnt <= r_issue_cnt - C_CNT_ONE;
                    if (r_issue_cnt != C_CNT_ONE) begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                if (w_pop) begin
                    r_ret_cnt <= r_ret_cnt - C_CNT_ONE;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/rom_reader.md
# rom_reader

Sequential read master for the synchronous-read `rom` block. On a start pulse it walks a contiguous address range, drives the ROM's `address`/`enable` port, absorbs the ROM's one-cycle registered read latency, and presents the words as a valid/ready stream with a last-word marker. It sits between a preloaded ROM (sprite, LUT or sample tables) and whichever consumer streams those tables out.

## Interface
Parameters:
- `ROM_WIDTH`, 1, word width; must match the attached ROM.
- `ROM_ADDR_BITS`, 14, ROM address width; must match the attached ROM.

Ports:
- `clk`  in  1  single clock; everything is synchronous to its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request pulse; sampled only in IDLE.
- `base_addr`  in  ROM_ADDR_BITS  first address; sampled with `start`.
- `length`  in  ROM_ADDR_BITS+1  word count, 0..2^ROM_ADDR_BITS; sampled with `start`.
- `busy`  out  1  a transfer is in progress.
- `done`  out  1  one-cycle pulse when the transfer ends.
- `rom_address`  out  ROM_ADDR_BITS  to ROM `address`.
- `rom_enable`  out  1  to ROM `enable`.
- `rom_data`  in  ROM_WIDTH  from ROM `output_data`.
- `m_data`  out  ROM_WIDTH  stream data.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready from the consumer.
- `m_last`  out  1  high with the final word of a transfer.

## Operation
- States:
  - IDLE: `start` loads the address counter with `base_addr` and the issue and return counters with `length`, then moves to RUN. `start` is ignored in every other state.
  - RUN: issues reads until the issue counter reaches 0, then moves to DRAIN.
  - DRAIN: waits until every word has been handshaken.
  - DONE: lasts one cycle; `done`=1; returns to IDLE.
- `length`=0: IDLE→DONE directly. No `rom_enable` and no stream beat.
- Issue rule: `rom_enable`=1 in RUN iff `count + pending − pop < 2`.
  - `count`: occupancy of the 2-entry output buffer.
  - `pending`: a read was issued in the previous cycle.
  - `pop` = `m_valid & m_ready`.
  - Each issue increments the address and decrements the issue counter.
- `rom_address` wraps modulo 2^ROM_ADDR_BITS: base 0x3FFF, length 3 reads 0x3FFF, 0x0000, 0x0001.
- The word returned one cycle after an issue is captured into the buffer unconditionally. The issue rule guarantees space, so no word is dropped.
- `m_last` is asserted with the buffer head when the return counter equals 1. Each pop decrements the return counter.
- `m_data`/`m_valid`/`m_last` are held stable while `m_valid & !m_ready`.
- `rom_address` is don't-care whenever `rom_enable`=0. Hold it at the last value.

## Timing
- Reset values: `busy`=0, `done`=0, `rom_enable`=0, `rom_address`=0, `m_valid`=0, `m_last`=0, `m_data`=0. State=IDLE, buffer empty, `pending`=0.
- Reset mid-transfer: the next cycle shows the reset values. The in-flight ROM word is discarded and never appears on the stream.
- Latency, with `start` high in cycle 0:
  - `busy`=1 and first `rom_enable` in cycle 1.
  - first `m_valid` in cycle 3.
- Throughput: with `m_ready` held at 1, one word per cycle and no bubbles.
- Backpressure: no more than 2 words are ever buffered plus in flight.
- `done` pulses in the cycle after the handshake of the `m_last` word.
  - `busy` stays 1 through the `done` cycle and is 0 the next cycle.
  - A new `start` is accepted in the cycle after `done`.

## Structure
- Shared package `rom_reader_pkg`: state enum (IDLE, RUN, DRAIN, DONE) and the buffer depth constant 2.
- Sub-module `rom_stream_fifo`: 2-entry register FIFO.
  - Ports: push, pop, count, head data, last flag.
  - Synchronous active-high reset.
  - The issue logic uses `count`.

## Test plan
- ROM preloaded so each word = its address, ROM_WIDTH=16, ROM_ADDR_BITS=4. base 2, length 5, `m_ready`=1 → stream 2,3,4,5,6 on consecutive cycles; first `m_valid` 3 cycles after `start`; `m_last` only with 6; `done` one cycle later.
- Same setup, base 14, length 4 → addresses 14,15,0,1; data 14,15,0,1.
- `length`=0 → `done` the cycle after `start`; no `rom_enable`; `m_valid` never asserts.
- Random `m_ready` (50%), length 16 → all 16 words in order, none lost or duplicated; data held stable while stalled; `count + pending` ≤ 2 every cycle.
- `reset` asserted on the 3rd word of a length-8 transfer → all outputs at reset values the next cycle. A new `start` (base 0, length 2) then yields exactly 0,1.
- `start` pulsed during RUN → ignored; only the original transfer completes, with a single `done`.
